// File: rtl/dds_slew_accum.sv
// Multi-channel DDS accumulator with slew-limited increment changes and phase nudges; DDS_DITHER_EN adds LFSR dither.
// Latency: dds_msb/current_increment/slewing are registered, one edge after their inputs.
// Backpressure: phase_adj_ready drops for one cycle after each accepted nudge (max one adjust per 2 cycles).
module dds_slew_accum #(
    parameter int          N_CH              = 2,
    parameter int          ACC_WIDTH         = 32,
    parameter int          STEP_WIDTH        = 16,
    parameter int          PERIOD_WIDTH      = 16,
    parameter logic [63:0] DEFAULT_INCREMENT = 64'h33333333,
    parameter int          DITHER_BITS       = 4
) (
    input  logic                      clk_ref,
    input  logic                      clk_ref_aresetn,
    input  logic [N_CH*ACC_WIDTH-1:0] target_increment,
    input  logic [STEP_WIDTH-1:0]     slew_step,
    input  logic [PERIOD_WIDTH-1:0]   slew_period,
    input  logic                      phase_adj_valid,
    output logic                      phase_adj_ready,
    input  logic [2:0]                phase_adj_ch,
    input  logic [ACC_WIDTH-1:0]      phase_adj_value,
    output logic [N_CH-1:0]           dds_msb,
    output logic [N_CH*ACC_WIDTH-1:0] current_increment,
    output logic [N_CH-1:0]           slewing
);

    typedef enum logic [1:0] {IDLE, UP, DOWN} slew_state_t;

    localparam logic [ACC_WIDTH-1:0] DEF_INC = ACC_WIDTH'(DEFAULT_INCREMENT);

    if (N_CH < 1 || N_CH > 8) begin : g_bad_n_ch
        $error("dds_slew_accum: N_CH must be in 1..8");
    end
    if (DITHER_BITS < 1 || DITHER_BITS > 16) begin : g_bad_dither_bits
        $error("dds_slew_accum: DITHER_BITS must be in 1..16");
    end

    logic [ACC_WIDTH-1:0]    acc      [N_CH];
    logic [ACC_WIDTH-1:0]    acc_next [N_CH];
    logic [ACC_WIDTH-1:0]    cur_inc  [N_CH];
    logic [ACC_WIDTH-1:0]    cur_next [N_CH];
    logic [ACC_WIDTH-1:0]    tgt      [N_CH];
    logic [ACC_WIDTH-1:0]    gap      [N_CH];
    logic [ACC_WIDTH-1:0]    stride   [N_CH];
    logic [ACC_WIDTH-1:0]    adj_term [N_CH];
    slew_state_t             state    [N_CH];
    slew_state_t             dir      [N_CH];
    logic [ACC_WIDTH-1:0]    step_ext;
    logic [PERIOD_WIDTH-1:0] tick_cnt;
    logic                    tick;
    logic                    adj_pend;
    logic [2:0]              adj_ch;
    logic [ACC_WIDTH-1:0]    adj_val;

`ifdef DDS_DITHER_EN
    logic [15:0]          lfsr;
    logic [ACC_WIDTH-1:0] dither;

    // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right.
    always_ff @(posedge clk_ref) begin
        if (!clk_ref_aresetn) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    assign dither = ACC_WIDTH'(lfsr[DITHER_BITS-1:0]);
`endif

    // Exact equality only: lowering slew_period below the count wraps the counter instead of ticking early.
    assign tick = (tick_cnt == slew_period);

    always_comb begin
        step_ext          = ACC_WIDTH'(slew_step);
        current_increment = '0;
        slewing           = '0;
        for (int c = 0; c < N_CH; c++) begin
            tgt[c] = target_increment[c*ACC_WIDTH +: ACC_WIDTH];
            if (tgt[c] > cur_inc[c]) begin
                dir[c] = UP;
                gap[c] = tgt[c] - cur_inc[c];
            end else if (tgt[c] < cur_inc[c]) begin
                dir[c] = DOWN;
                gap[c] = cur_inc[c] - tgt[c];
            end else begin
                dir[c] = IDLE;
                gap[c] = '0;
            end
            // Clamping to the remaining gap keeps a reversed or shortened ramp from overshooting.
            stride[c]   = (gap[c] < step_ext) ? gap[c] : step_ext;
            cur_next[c] = cur_inc[c];
            if (tick && dir[c] == UP) begin
                cur_next[c] = cur_inc[c] + stride[c];
            end else if (tick && dir[c] == DOWN) begin
                cur_next[c] = cur_inc[c] - stride[c];
            end
            adj_term[c] = (adj_pend && adj_ch == 3'(c)) ? adj_val : '0;
`ifdef DDS_DITHER_EN
            acc_next[c] = acc[c] + cur_inc[c] + adj_term[c] + dither;
`else
            acc_next[c] = acc[c] + cur_inc[c] + adj_term[c];
`endif
            current_increment[c*ACC_WIDTH +: ACC_WIDTH] = cur_inc[c];
            slewing[c] = (state[c] != IDLE);
        end
    end

    always_ff @(posedge clk_ref) begin
        if (!clk_ref_aresetn) begin
            tick_cnt        <= '0;
            phase_adj_ready <= 1'b0;
            adj_pend        <= 1'b0;
            adj_ch          <= '0;
            adj_val         <= '0;
            dds_msb         <= '0;
            for (int c = 0; c < N_CH; c++) begin
                acc[c]     <= '0;
                cur_inc[c] <= DEF_INC;
                state[c]   <= IDLE;
            end
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + PERIOD_WIDTH'(1);

            // The accepted nudge lands on the next edge; ready is restored on that same edge.
            if (phase_adj_ready && phase_adj_valid) begin
                phase_adj_ready <= 1'b0;
                adj_pend        <= 1'b1;
                adj_ch          <= phase_adj_ch;
                adj_val         <= phase_adj_value;
            end else begin
                phase_adj_ready <= 1'b1;
                adj_pend        <= 1'b0;
            end

            for (int c = 0; c < N_CH; c++) begin
                acc[c]     <= acc_next[c];
                dds_msb[c] <= acc_next[c][ACC_WIDTH-1];
                cur_inc[c] <= cur_next[c];
                state[c]   <= dir[c];
            end
        end
    end

endmodule
